// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants and types for the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    // One pending register-file write
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Which producer owns the write port in a given cycle
    typedef enum logic [1:0] {
        WB_NONE   = 2'd0,
        WB_PIPE   = 2'd1,
        WB_BUF    = 2'd2,
        WB_BYPASS = 2'd3
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_kill_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_kill_fifo
//  Description : Small compacting FIFO of multdiv results. Entries whose rd
//                matches kill_rd are dropped; survivors slide toward the
//                head keeping age order. Head reflects the current cycle's
//                kills so the caller can pop the oldest survivor directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_kill_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                         clock,
    input  logic                         ctrl_reset,
    input  logic                         push,
    input  logic [AW-1:0]                push_rd,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    input  logic                         kill_en,
    input  logic [AW-1:0]                kill_rd,
    output logic [AW-1:0]                head_rd,
    output logic [DW-1:0]                head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_rd   [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [DEPTH-1:0] w_keep;
    logic [DEPTH-1:0] w_valid_n;
    logic [AW-1:0]    w_rd_n   [DEPTH];
    logic [DW-1:0]    w_data_n [DEPTH];
    int               w_rank   [DEPTH];
    int               w_kept;
    int               w_tail;
    int               w_total;

    // Apply kills, pick the head, then compact survivors (minus popped head) and append push
    always_comb begin
        w_kept     = 0;
        head_rd    = '0;
        head_data  = '0;
        head_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_keep[i] = r_valid[i] & ~(kill_en & (r_rd[i] == kill_rd));
            // destination slot of entry i once the popped head is removed
            w_rank[i] = w_kept - (pop ? 1 : 0);
            if (w_keep[i]) begin
                w_kept = w_kept + 1;
            end
        end
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_keep[i]) begin
                head_rd    = r_rd[i];
                head_data  = r_data[i];
                head_valid = 1'b1;
            end
        end
        w_tail = w_kept - ((pop && (w_kept > 0)) ? 1 : 0);
        for (int j = 0; j < DEPTH; j++) begin
            w_valid_n[j] = 1'b0;
            w_rd_n[j]    = r_rd[j];
            w_data_n[j]  = r_data[j];
            for (int i = 0; i < DEPTH; i++) begin
                if (w_keep[i] && (w_rank[i] == j)) begin
                    w_valid_n[j] = 1'b1;
                    w_rd_n[j]    = r_rd[i];
                    w_data_n[j]  = r_data[i];
                end
            end
            if (push && (w_tail == j)) begin
                w_valid_n[j] = 1'b1;
                w_rd_n[j]    = push_rd;
                w_data_n[j]  = push_data;
            end
        end
        w_total = w_tail + ((push && (w_tail < DEPTH)) ? 1 : 0);
    end

    // Storage update; reset empties every slot
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_n;
            r_count <= CNT_W'(w_total);
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= w_rd_n[i];
                r_data[i] <= w_data_n[i];
            end
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Register-file writeback arbiter. MEM/WB results always win
//                the write port; multdiv results bypass straight through
//                when the port is free or wait in a kill-able buffer. A pipe
//                write kills older buffered writes to the same register so
//                write-after-write order holds. Writes to r0 are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             ctrl_reset,
    input  logic                             pipe_valid,
    input  logic [ADDR_W-1:0]                pipe_rd,
    input  logic [DATA_W-1:0]                pipe_data,
    input  logic                             md_valid,
    input  logic [ADDR_W-1:0]                md_rd,
    input  logic [DATA_W-1:0]                md_data,
    output logic                             md_ready,
    output logic                             ctrl_writeEnable,
    output logic [ADDR_W-1:0]                ctrl_writeReg,
    output logic [DATA_W-1:0]                data_writeReg,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count
);
    import wb_pkg::*;

    localparam int                CNT_W     = $clog2(BUF_DEPTH+1);
    localparam logic [ADDR_W-1:0] C_ZERO_RD = ADDR_W'(ZERO_REG);

    logic              w_pipe_wr;
    logic              w_md_xfer;
    logic              w_md_live;
    logic              w_push;
    logic              w_pop;
    wb_src_e           w_sel;
    logic [ADDR_W-1:0] w_head_rd;
    logic [DATA_W-1:0] w_head_data;
    logic              w_head_valid;
    logic [CNT_W-1:0]  w_count;

    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;

    // Ready depends only on stored occupancy, never on this cycle's inputs
    assign md_ready  = (w_count < CNT_W'(BUF_DEPTH));
    assign buf_count = w_count;

    assign w_pipe_wr = pipe_valid & (pipe_rd != C_ZERO_RD);
    assign w_md_xfer = md_valid & md_ready;
    // A same-cycle pipe write to the same rd is younger, so the md result is dead on arrival
    assign w_md_live = w_md_xfer & (md_rd != C_ZERO_RD) & ~(w_pipe_wr & (md_rd == pipe_rd));

    wb_kill_fifo #(
        .DEPTH (BUF_DEPTH),
        .DW    (DATA_W),
        .AW    (ADDR_W)
    ) u_fifo (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (w_push),
        .push_rd    (md_rd),
        .push_data  (md_data),
        .pop        (w_pop),
        .kill_en    (w_pipe_wr),
        .kill_rd    (pipe_rd),
        .head_rd    (w_head_rd),
        .head_data  (w_head_data),
        .head_valid (w_head_valid),
        .count      (w_count)
    );

    // Write-port owner: pipe, then oldest buffered entry, then direct bypass
    always_comb begin
        w_sel  = WB_NONE;
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (w_pipe_wr) begin
            w_sel  = WB_PIPE;
            w_push = w_md_live;
        end else if (w_head_valid) begin
            w_sel  = WB_BUF;
            w_pop  = 1'b1;
            w_push = w_md_live;
        end else if (w_md_live) begin
            w_sel  = WB_BYPASS;
        end
    end

    // Registered write port; index and data hold when nothing is written
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= (w_sel != WB_NONE);
            case (w_sel)
                WB_PIPE: begin
                    r_wreg  <= pipe_rd;
                    r_wdata <= pipe_data;
                end
                WB_BUF: begin
                    r_wreg  <= w_head_rd;
                    r_wdata <= w_head_data;
                end
                WB_BYPASS: begin
                    r_wreg  <= md_rd;
                    r_wdata <= md_data;
                end
                default: ;
            endcase
        end
    end

    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: directed vector table,
//                asynchronous reset sequence and a randomized run against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [1:0]  buf_count;

    always #5 clock = ~clock;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .BUF_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .pipe_valid       (pipe_valid),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .buf_count        (buf_count)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cnt;
    } exp_t;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        rdy;
        exp_t        e;
    } vec_t;

    int      checks = 0;
    int      errors = 0;
    exp_t    sb[$];
    wb_req_t mdl_q[$];
    logic [4:0]  mdl_rd   = '0;
    logic [31:0] mdl_data = '0;
    vec_t    tbl[32];

    function automatic exp_t mke(input logic we, input logic [4:0] rd, input logic [31:0] d, input int cnt);
        exp_t e;
        e.we = we; e.rd = rd; e.data = d; e.cnt = cnt;
        return e;
    endfunction

    function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic rdy, input logic we, input logic [4:0] wrd,
                                input logic [31:0] wd, input int cnt);
        vec_t v;
        v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
        v.rdy = rdy; v.e = mke(we, wrd, wd, cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, check ready before the edge, queue the expectation, compare after the edge
    task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic rdy, input exp_t e, input string tag);
        exp_t got;
        @(negedge clock);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        md_valid = mv; md_rd = mrd; md_data = md;
        #1;
        chk($sformatf("%s md_ready", tag), {31'd0, md_ready}, {31'd0, rdy});
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk($sformatf("%s writeEnable", tag), {31'd0, ctrl_writeEnable}, {31'd0, got.we});
        chk($sformatf("%s writeReg", tag), {27'd0, ctrl_writeReg}, {27'd0, got.rd});
        chk($sformatf("%s writeData", tag), data_writeReg, got.data);
        chk($sformatf("%s buf_count", tag), {30'd0, buf_count}, got.cnt);
    endtask

    // Reference model: queue buffer, kills first, then pipe / oldest / bypass priority
    task automatic model(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         output logic rdy, output exp_t e);
        logic    pw;
        logic    live;
        wb_req_t r;
        rdy = (mdl_q.size() < DEPTH);
        pw  = pv && (prd != 5'd0);
        if (pw) begin
            for (int k = mdl_q.size() - 1; k >= 0; k--) begin
                if (mdl_q[k].rd == prd) mdl_q.delete(k);
            end
        end
        live = mv && rdy && (mrd != 5'd0) && !(pw && (mrd == prd));
        r.rd = mrd; r.data = md;
        e.we = 1'b1;
        if (pw) begin
            mdl_rd = prd; mdl_data = pd;
            if (live) mdl_q.push_back(r);
        end else if (mdl_q.size() > 0) begin
            wb_req_t h;
            h = mdl_q.pop_front();
            mdl_rd = h.rd; mdl_data = h.data;
            if (live) mdl_q.push_back(r);
        end else if (live) begin
            mdl_rd = mrd; mdl_data = md;
        end else begin
            e.we = 1'b0;
        end
        e.rd = mdl_rd; e.data = mdl_data; e.cnt = mdl_q.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r_rdy;
        exp_t e;
        logic pv, mv;
        logic [4:0] prd, mrd;
        logic [31:0] pd, md;

        ctrl_reset = 1'b0;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        md_valid = 1'b0; md_rd = '0; md_data = '0;

        tbl[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 32'h0,  1, 1, 3, 32'hDEADBEEF, 0);
        tbl[1]  = mk(0, 0, 32'h0,   1, 7, 32'h12,  1, 1, 7, 32'h12, 0);
        tbl[2]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 7, 32'h12, 0);
        tbl[3]  = mk(1, 1, 32'h100, 1, 5, 32'h55,  1, 1, 1, 32'h100, 1);
        tbl[4]  = mk(1, 2, 32'h200, 1, 6, 32'h66,  1, 1, 2, 32'h200, 2);
        tbl[5]  = mk(1, 3, 32'h300, 0, 0, 32'h0,   0, 1, 3, 32'h300, 2);
        tbl[6]  = mk(1, 4, 32'h400, 1, 8, 32'h88,  0, 1, 4, 32'h400, 2);
        tbl[7]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 5, 32'h55, 1);
        tbl[8]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 6, 32'h66, 0);
        tbl[9]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 6, 32'h66, 0);
        tbl[10] = mk(1, 10, 32'hA0, 1, 9, 32'hAA,  1, 1, 10, 32'hA0, 1);
        tbl[11] = mk(1, 9, 32'hBB,  0, 0, 32'h0,   1, 1, 9, 32'hBB, 0);
        tbl[12] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 9, 32'hBB, 0);
        tbl[13] = mk(0, 0, 32'h0,   1, 0, 32'h77,  1, 0, 9, 32'hBB, 0);
        tbl[14] = mk(1, 0, 32'h99,  0, 0, 32'h0,   1, 0, 9, 32'hBB, 0);
        tbl[15] = mk(1, 0, 32'h99,  1, 11, 32'h11, 1, 1, 11, 32'h11, 0);
        tbl[16] = mk(1, 12, 32'hC0, 1, 12, 32'hC1, 1, 1, 12, 32'hC0, 0);
        tbl[17] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 12, 32'hC0, 0);
        tbl[18] = mk(1, 13, 32'hD0, 1, 14, 32'hE0, 1, 1, 13, 32'hD0, 1);
        tbl[19] = mk(0, 0, 32'h0,   1, 15, 32'hF0, 1, 1, 14, 32'hE0, 1);
        tbl[20] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 15, 32'hF0, 0);
        tbl[21] = mk(1, 1, 32'h1,   1, 16, 32'hA,  1, 1, 1, 32'h1, 1);
        tbl[22] = mk(1, 2, 32'h2,   1, 16, 32'hB,  1, 1, 2, 32'h2, 2);
        tbl[23] = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 16, 32'hA, 1);
        tbl[24] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 16, 32'hB, 0);
        tbl[25] = mk(1, 3, 32'h3,   1, 17, 32'h17, 1, 1, 3, 32'h3, 1);
        tbl[26] = mk(1, 4, 32'h4,   1, 18, 32'h18, 1, 1, 4, 32'h4, 2);
        tbl[27] = mk(1, 17, 32'h170, 0, 0, 32'h0,  0, 1, 17, 32'h170, 1);
        tbl[28] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 18, 32'h18, 0);
        tbl[29] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 18, 32'h18, 0);
        tbl[30] = mk(1, 5, 32'h5,   1, 19, 32'h19, 1, 1, 5, 32'h5, 1);
        tbl[31] = mk(1, 0, 32'h99,  0, 0, 32'h0,   1, 1, 19, 32'h19, 0);

        // Reset state
        #2;
        chk("reset writeEnable", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("reset writeReg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("reset writeData", data_writeReg, 32'd0);
        chk("reset buf_count", {30'd0, buf_count}, 32'd0);
        chk("reset md_ready", {31'd0, md_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        ctrl_reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 32; i++) begin
            step(tbl[i].pv, tbl[i].prd, tbl[i].pd, tbl[i].mv, tbl[i].mrd, tbl[i].md,
                 tbl[i].rdy, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Asynchronous reset with a full buffer
        step(1, 20, 32'h20, 1, 21, 32'h21, 1, mke(1, 20, 32'h20, 1), "rst_fill0");
        step(1, 22, 32'h22, 1, 23, 32'h23, 1, mke(1, 22, 32'h22, 2), "rst_fill1");
        #2;
        ctrl_reset = 1'b0;
        #1;
        chk("async reset writeEnable", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("async reset writeReg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("async reset writeData", data_writeReg, 32'd0);
        chk("async reset buf_count", {30'd0, buf_count}, 32'd0);
        chk("async reset md_ready", {31'd0, md_ready}, 32'd1);
        pipe_valid = 1'b0; md_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        ctrl_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, 0, 32'h0, 1, mke(0, 0, 32'h0, 0), $sformatf("post_rst%0d", i));
        end

        // Randomized traffic against the reference model
        mdl_q.delete();
        mdl_rd = '0;
        mdl_data = '0;
        for (int i = 0; i < 300; i++) begin
            pv  = ($urandom_range(0, 99) < 60);
            prd = 5'($urandom_range(0, 3));
            pd  = $urandom;
            mv  = ($urandom_range(0, 99) < 60);
            mrd = 5'($urandom_range(0, 3));
            md  = $urandom;
            model(pv, prd, pd, mv, mrd, md, r_rdy, e);
            step(pv, prd, pd, mv, mrd, md, r_rdy, e, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter that drives the single write port of the 32x32 register file (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Merges two result producers: the in-order MEM/WB pipeline result, which has no backpressure, and the multi-cycle multdiv unit result, which uses a valid/ready handshake.
- Pipeline results always win; multdiv results wait in a small kill-able buffer. Write-after-write order is preserved, and register 0 writes are suppressed.

Parameters:
DATA_W, 32, data width of results and regfile write data
ADDR_W, 5, register index width
BUF_DEPTH, 2, number of multdiv result buffer entries (>=1)

Ports:
clock  in  1  system clock, rising edge
ctrl_reset  in  1  asynchronous, active-low reset
pipe_valid  in  1  MEM/WB result valid this cycle; always accepted
pipe_rd  in  ADDR_W  MEM/WB destination register
pipe_data  in  DATA_W  MEM/WB result
md_valid  in  1  multdiv result valid
md_rd  in  ADDR_W  multdiv destination register
md_data  in  DATA_W  multdiv result
md_ready  out  1  arbiter can accept a multdiv result
ctrl_writeEnable  out  1  regfile write enable (registered)
ctrl_writeReg  out  ADDR_W  regfile write index (registered)
data_writeReg  out  DATA_W  regfile write data (registered)
buf_count  out  $clog2(BUF_DEPTH+1)  live buffer entries, for debug and perf counters

Behaviour:
- Reset (ctrl_reset=0, asynchronous):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - Buffer emptied, buf_count=0.
  - Reset mid-operation discards all buffered entries and any in-flight write.
- md_ready = (buf_count < BUF_DEPTH).
  - Combinational from state only; it must not depend on md_valid or pipe_valid.
  - It is 1 during and after reset.
- An md transfer happens when md_valid & md_ready on a rising edge.
  - If md_rd=0, the transfer is accepted and discarded.
- Ordering rule (decided): a pipe result is always younger than any outstanding or arriving multdiv result.
  - Each cycle with pipe_valid & pipe_rd!=0, every buffered entry whose rd equals pipe_rd is killed (removed, buf_count decreases).
  - An md transfer with md_rd==pipe_rd in the same cycle is accepted and discarded.
- Per-cycle write-port selection, in priority order, registered onto the output ports at the next edge (latency 1 cycle):
  1. pipe_valid & pipe_rd!=0: write (pipe_rd, pipe_data).
  2. Buffer non-empty after kills: pop the oldest surviving entry and write it.
  3. Buffer empty and an md transfer is occurring with md_rd!=0 and not killed: write it directly (bypass, latency 1, not stored).
  4. Otherwise ctrl_writeEnable=0; ctrl_writeReg and data_writeReg hold their previous values.
- pipe_valid with pipe_rd=0 counts as idle and does not block the buffer.
- Buffer is FIFO order. Push, pop and kills may all occur in one cycle:
  - count_next = count + push - pop - kills.
  - Surviving entries compact toward the head, preserving age order.
- Full buffer (buf_count=BUF_DEPTH): md_ready=0, pipe writes continue; the buffer drains only in cycles without a pipe write.
- An md transfer arriving while the buffer is non-empty (and no pipe write) is pushed; the oldest entry is popped the same cycle.
- Duplicate rd among buffered entries is legal; both write in order.

Decomposition:
- Package wb_pkg:
  - Constants DATA_W, ADDR_W and ZERO_REG=0.
  - Typedef wb_req_t {rd[ADDR_W], data[DATA_W]}.
  - Typedef wb_src_e {WB_NONE, WB_PIPE, WB_BUF, WB_BYPASS} for the select logic and coverage.
- One sub-module, wb_kill_fifo:
  - BUF_DEPTH-entry compacting FIFO with per-entry valid, push, pop and kill_en/kill_rd inputs.
  - Outputs: head entry, head_valid, count.

Test Plan:
- Reset release, then pipe_valid=1, rd=3, data=0xDEADBEEF -> next cycle ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=0xDEADBEEF; md_ready=1 throughout.
- md_valid=1 rd=7 data=0x12 with idle pipe and empty buffer -> bypass write (7, 0x12) one cycle later; buf_count stays 0.
- pipe writes on 4 consecutive cycles while md presents rd=5 then rd=6 -> buf_count=2 and md_ready=0 in cycle 3; after the pipe goes idle, writes (5,..) then (6,..) in order; md_ready returns to 1.
- Buffer holds rd=9 data=0xAA; pipe writes rd=9 data=0xBB -> buffered entry killed, buf_count=0, only (9, 0xBB) is written.
- md rd=0 or pipe rd=0 -> transfer accepted, ctrl_writeEnable stays 0, buf_count unchanged.
- ctrl_reset asserted with buf_count=2 mid-stream -> outputs 0 and buf_count=0 immediately (asynchronously); after release, no stale writes occur.
